// File: rtl/conv_scheduler.sv
// ---------------------------------------------------------------------------
// conv_scheduler
//
// Top-level sequencer for the 3x3 convolution datapath. For each of
// NUM_FILTERS kernels it reads nine weights from the kernel ROM, then holds
// the datapath enable until the datapath reports completion. Every result
// the datapath stores is remapped into one shared feature-map RAM. Each
// filter's output map occupies a contiguous block starting at
// filter*(H-2)*(W-2).
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_start          start pulse, accepted only while idle
//   o_busy           high from the cycle after an accepted start until done
//   o_done           one-cycle pulse when every filter has finished
//   o_filter_idx     filter currently loading or running
//   o_krom_addr      kernel ROM read address (ROM has 1-cycle latency)
//   i_krom_data      kernel ROM read data
//   o_kernel0..8     registered weights, row-major
//   o_conv_en        level enable to the datapath
//   i_conv_done      datapath completion flag
//   i_conv_store     datapath result-valid strobe
//   i_conv_result    datapath result
//   i_conv_addr      datapath output-pixel address
//   o_fmap_we        feature-map write enable
//   o_fmap_addr      feature-map write address
//   o_fmap_data      feature-map write data
// ---------------------------------------------------------------------------
module conv_scheduler #(
   parameter int NUM_FILTERS = 4,
   parameter int H           = 28,
   parameter int W           = 28,
   parameter int KADDR_W     = 6,
   parameter int OADDR_W     = 12
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic [3:0]         o_filter_idx,
   output logic [KADDR_W-1:0] o_krom_addr,
   input  logic [7:0]         i_krom_data,
   output logic [7:0]         o_kernel0,
   output logic [7:0]         o_kernel1,
   output logic [7:0]         o_kernel2,
   output logic [7:0]         o_kernel3,
   output logic [7:0]         o_kernel4,
   output logic [7:0]         o_kernel5,
   output logic [7:0]         o_kernel6,
   output logic [7:0]         o_kernel7,
   output logic [7:0]         o_kernel8,
   output logic               o_conv_en,
   input  logic               i_conv_done,
   input  logic               i_conv_store,
   input  logic [7:0]         i_conv_result,
   input  logic [9:0]         i_conv_addr,
   output logic               o_fmap_we,
   output logic [OADDR_W-1:0] o_fmap_addr,
   output logic [7:0]         o_fmap_data
);

   localparam int         MAP_SIZE    = (H - 2) * (W - 2);
   localparam logic [3:0] LAST_FILTER = 4'(NUM_FILTERS - 1);
   localparam logic [3:0] LOAD_LAST   = 4'd9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_GAP,
      S_FINISH
   } state_t;

   state_t               r_state;
   state_t               w_stateNext;
   logic [3:0]           r_loadCnt;
   logic [3:0]           w_loadCntNext;
   logic [3:0]           r_filterIdx;
   logic [3:0]           w_filterIdxNext;
   logic [KADDR_W-1:0]   r_kbase;
   logic [KADDR_W-1:0]   w_kbaseNext;
   logic [OADDR_W-1:0]   r_fbase;
   logic [OADDR_W-1:0]   w_fbaseNext;
   logic [7:0]           r_kernel [0:8];
   logic                 r_fmapWe;
   logic [OADDR_W-1:0]   r_fmapAddr;
   logic [7:0]           r_fmapData;
   logic                 w_acceptStore;

   // Next-state logic. The load counter is zero in every state except LOAD,
   // so entering LOAD always starts from k=0. The ROM and feature-map bases
   // are running sums stepped in GAP, so no multiplier is needed. They are
   // cleared while idle and on the way out of FINISH so a new run starts
   // from filter 0.
   always_comb begin
      w_stateNext     = r_state;
      w_loadCntNext   = 4'd0;
      w_filterIdxNext = r_filterIdx;
      w_kbaseNext     = r_kbase;
      w_fbaseNext     = r_fbase;
      case (r_state)
         S_IDLE: begin
            w_filterIdxNext = 4'd0;
            w_kbaseNext     = '0;
            w_fbaseNext     = '0;
            if (i_start) begin
               w_stateNext = S_LOAD;
            end
         end
         S_LOAD: begin
            if (r_loadCnt == LOAD_LAST) begin
               w_stateNext = S_RUN;
            end else begin
               w_loadCntNext = r_loadCnt + 4'd1;
            end
         end
         S_RUN: begin
            if (i_conv_done) begin
               w_stateNext = S_GAP;
            end
         end
         S_GAP: begin
            if (r_filterIdx == LAST_FILTER) begin
               w_stateNext = S_FINISH;
            end else begin
               w_filterIdxNext = r_filterIdx + 4'd1;
               w_kbaseNext     = r_kbase + KADDR_W'(9);
               w_fbaseNext     = r_fbase + OADDR_W'(MAP_SIZE);
               w_stateNext     = S_LOAD;
            end
         end
         S_FINISH: begin
            w_filterIdxNext = 4'd0;
            w_kbaseNext     = '0;
            w_fbaseNext     = '0;
            w_stateNext     = S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   // Stores are only honoured while the datapath is enabled; a store that
   // coincides with conv_done is still inside RUN and is therefore kept.
   assign w_acceptStore = (r_state == S_RUN) && i_conv_store;

   // State, counters, weights and the registered write port. The ROM data
   // seen at load step k belongs to the address issued at step k-1, so
   // steps 1..9 fill kernel0..kernel8. Weights are only written in LOAD and
   // therefore hold through RUN, GAP and after done.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_loadCnt   <= 4'd0;
         r_filterIdx <= 4'd0;
         r_kbase     <= '0;
         r_fbase     <= '0;
         for (int i = 0; i < 9; i++) begin
            r_kernel[i] <= 8'd0;
         end
         r_fmapWe   <= 1'b0;
         r_fmapAddr <= '0;
         r_fmapData <= 8'd0;
      end else begin
         r_state     <= w_stateNext;
         r_loadCnt   <= w_loadCntNext;
         r_filterIdx <= w_filterIdxNext;
         r_kbase     <= w_kbaseNext;
         r_fbase     <= w_fbaseNext;
         if (r_state == S_LOAD) begin
            for (int i = 0; i < 9; i++) begin
               if (r_loadCnt == 4'(i + 1)) begin
                  r_kernel[i] <= i_krom_data;
               end
            end
         end
         r_fmapWe <= w_acceptStore;
         if (w_acceptStore) begin
            r_fmapAddr <= r_fbase + OADDR_W'(i_conv_addr);
            r_fmapData <= i_conv_result;
         end
      end
   end

   // ROM address: base plus load step during steps 0..8, otherwise parked
   // at the base so it reads 0 out of reset and while idle.
   always_comb begin
      o_krom_addr = r_kbase;
      if ((r_state == S_LOAD) && (r_loadCnt != LOAD_LAST)) begin
         o_krom_addr = r_kbase + KADDR_W'(r_loadCnt);
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_FINISH);
   assign o_conv_en    = (r_state == S_RUN);
   assign o_filter_idx = r_filterIdx;
   assign o_fmap_we    = r_fmapWe;
   assign o_fmap_addr  = r_fmapAddr;
   assign o_fmap_data  = r_fmapData;

   assign o_kernel0 = r_kernel[0];
   assign o_kernel1 = r_kernel[1];
   assign o_kernel2 = r_kernel[2];
   assign o_kernel3 = r_kernel[3];
   assign o_kernel4 = r_kernel[4];
   assign o_kernel5 = r_kernel[5];
   assign o_kernel6 = r_kernel[6];
   assign o_kernel7 = r_kernel[7];
   assign o_kernel8 = r_kernel[8];

endmodule

// File: tb/tb_conv_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_scheduler
//
// Directed-sequence bench for conv_scheduler with randomized ROM contents,
// store spacing and result data. Expected values come from the arithmetic
// rules of the scheduler: ROM address = filter*9 + k, weight i of filter f =
// rom[f*9+i], write address = filter*(H-2)*(W-2) + pixel.
// ---------------------------------------------------------------------------
module tb_conv_scheduler;

   localparam int NUM_FILTERS = 4;
   localparam int H           = 28;
   localparam int W           = 28;
   localparam int KADDR_W     = 6;
   localparam int OADDR_W     = 12;
   localparam int MAP_SIZE    = (H - 2) * (W - 2);

   logic               clk;
   logic               rst;
   logic               start;
   logic               busy;
   logic               done;
   logic [3:0]         filterIdx;
   logic [KADDR_W-1:0] kromAddr;
   logic [7:0]         kromData;
   logic [7:0]         kern [9];
   logic               convEn;
   logic               convDone;
   logic               convStore;
   logic [7:0]         convResult;
   logic [9:0]         convAddr;
   logic               fmapWe;
   logic [OADDR_W-1:0] fmapAddr;
   logic [7:0]         fmapData;

   logic [7:0] rom [NUM_FILTERS*9];
   int testCount  = 0;
   int failCount  = 0;
   int writeCount = 0;
   int doneCount  = 0;

   conv_scheduler #(
      .NUM_FILTERS(NUM_FILTERS), .H(H), .W(W), .KADDR_W(KADDR_W), .OADDR_W(OADDR_W)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start),
      .o_busy(busy), .o_done(done), .o_filter_idx(filterIdx),
      .o_krom_addr(kromAddr), .i_krom_data(kromData),
      .o_kernel0(kern[0]), .o_kernel1(kern[1]), .o_kernel2(kern[2]),
      .o_kernel3(kern[3]), .o_kernel4(kern[4]), .o_kernel5(kern[5]),
      .o_kernel6(kern[6]), .o_kernel7(kern[7]), .o_kernel8(kern[8]),
      .o_conv_en(convEn), .i_conv_done(convDone), .i_conv_store(convStore),
      .i_conv_result(convResult), .i_conv_addr(convAddr),
      .o_fmap_we(fmapWe), .o_fmap_addr(fmapAddr), .o_fmap_data(fmapData)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Kernel ROM model with one cycle of read latency.
   always @(posedge clk) begin
      kromData <= rom[kromAddr];
   end

   // Counts write strobes and done pulses, sampled away from the active edge.
   always @(negedge clk) begin
      if (fmapWe === 1'b1) writeCount++;
      if (done === 1'b1) doneCount++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic store, input logic [9:0] addr,
                                input logic [7:0] res, input logic cdone);
      start      = st;
      convStore  = store;
      convAddr   = addr;
      convResult = res;
      convDone   = cdone;
   endtask

   // Entered at LOAD step 0 of filter f; leaves in the first RUN cycle.
   task automatic doLoad(input int f, input bit spurious);
      checkOutput("load_busy", busy, 1);
      checkOutput("load_filter_idx", filterIdx, f);
      for (int k = 0; k < 10; k++) begin
         if (k <= 8) checkOutput("krom_addr", kromAddr, f * 9 + k);
         if (spurious && k == 4) checkOutput("store_in_load", fmapWe, 0);
         if (k == 9) checkOutput("en_low_last_load", convEn, 0);
         if (spurious && k == 3) applyStimulus(0, 1, 10'd7, 8'h55, 0);
         else applyStimulus(0, 0, 10'd0, 8'h00, 0);
         tick();
      end
      checkOutput("run_conv_en", convEn, 1);
      for (int i = 0; i < 9; i++) checkOutput("kernel", kern[i], rom[f * 9 + i]);
   endtask

   // Entered in the first RUN cycle; leaves in the GAP cycle after conv_done.
   task automatic doRun(input int f, input int nStores, input bit startPulse);
      logic [7:0] res;
      if (startPulse) begin
         applyStimulus(1, 0, 10'd0, 8'h00, 0);
         tick();
         applyStimulus(0, 0, 10'd0, 8'h00, 0);
         checkOutput("start_in_run_idx", filterIdx, f);
         checkOutput("start_in_run_en", convEn, 1);
      end
      for (int p = 0; p < nStores; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(0, 0, 10'd0, 8'h00, 0);
            tick();
            checkOutput("idle_no_write", fmapWe, 0);
         end
         res = (f == 1 && p == 5) ? 8'hA7 : 8'($urandom);
         applyStimulus(0, 1, 10'(p), res, (p == nStores - 1));
         tick();
         checkOutput("fmap_write", {fmapWe, fmapAddr, fmapData},
                     {1'b1, 12'(f * MAP_SIZE + p), res});
         if (f == 1 && p == 5) checkOutput("remap_681", {fmapAddr, fmapData}, {12'd681, 8'hA7});
         if (f == 2 && p == 0) checkOutput("first_f2_1352", fmapAddr, 1352);
         if (f == 3 && p == MAP_SIZE - 1) checkOutput("last_f3_2703", fmapAddr, 2703);
      end
      checkOutput("gap_en_low", convEn, 0);
      checkOutput("gap_done_low", done, 0);
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
   endtask

   initial begin
      for (int n = 0; n < NUM_FILTERS * 9; n++) rom[n] = 8'($urandom_range(1, 255));
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
      rst = 1'b1;
      repeat (3) tick();

      // Reset values.
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_conv_en", convEn, 0);
      checkOutput("rst_fmap_we", fmapWe, 0);
      checkOutput("rst_filter_idx", filterIdx, 0);
      checkOutput("rst_krom_addr", kromAddr, 0);
      checkOutput("rst_fmap_addr", fmapAddr, 0);
      checkOutput("rst_fmap_data", fmapData, 0);
      for (int i = 0; i < 9; i++) checkOutput("rst_kernel", kern[i], 0);
      rst = 1'b0;
      tick();
      checkOutput("idle_busy", busy, 0);

      // Full four-filter run with a complete output map per filter.
      applyStimulus(1, 0, 10'd0, 8'h00, 0);
      tick();
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
      for (int f = 0; f < NUM_FILTERS; f++) begin
         doLoad(f, f == 0);
         doRun(f, MAP_SIZE, f == 1);
         tick();
      end
      checkOutput("finish_done", done, 1);
      checkOutput("finish_busy", busy, 1);
      tick();
      checkOutput("idle_done", done, 0);
      checkOutput("idle_busy_after", busy, 0);
      checkOutput("done_once", doneCount, 1);
      checkOutput("write_total", writeCount, NUM_FILTERS * MAP_SIZE);
      for (int i = 0; i < 9; i++) checkOutput("kernel_hold", kern[i], rom[(NUM_FILTERS - 1) * 9 + i]);

      // Second run, reset in the middle of filter 2.
      applyStimulus(1, 0, 10'd0, 8'h00, 0);
      tick();
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
      for (int f = 0; f < 2; f++) begin
         doLoad(f, 0);
         doRun(f, 3, 0);
         tick();
      end
      doLoad(2, 0);
      applyStimulus(0, 1, 10'd9, 8'h3C, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
      checkOutput("midrst_conv_en", convEn, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_filter_idx", filterIdx, 0);
      checkOutput("midrst_fmap_we", fmapWe, 0);
      for (int i = 0; i < 9; i++) checkOutput("midrst_kernel", kern[i], 0);
      tick();
      applyStimulus(1, 0, 10'd0, 8'h00, 0);
      tick();
      applyStimulus(0, 0, 10'd0, 8'h00, 0);
      doLoad(0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
